// File: rtl/mem_bus_initiator.sv
// Single-outstanding initiator for the simple memory-mapped peripheral bus.
// Optional bus timeout/abort logic is compiled in with `define MEM_TIMEOUT_EN.
module mem_bus_initiator #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_bus_initiator: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                write_q, write_d;
    logic [31:0]         rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic                err_q, err_d;
    logic [15:0]         tmo_cnt_q, tmo_cnt_d;
    logic [7:0]          err_count_q, err_count_d;
`endif

    // NOTE: every _d gets its current value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        write_d = write_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        err_d       = err_q;
        tmo_cnt_d   = tmo_cnt_q;
        err_count_d = err_count_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
                    wstrb_d = cmd_write ? cmd_wstrb : 4'h0;
                    state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end
            end

            ACCESS: begin
                if (mem_ready) begin
                    rdata_d = write_q ? 32'h0 : mem_rdata;
                    state_d = RESP;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Responder never answered: abort with an error response.
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            err_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            err_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            err_q       <= err_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_count_q <= err_count_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign mem_valid = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign rsp_rdata = rdata_q;

`ifdef MEM_TIMEOUT_EN
    assign rsp_err   = err_q;
    assign err_count = err_count_q;
`else
    assign rsp_err   = 1'b0;
    assign err_count = 8'h00;
`endif

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- Initiator (master) side of the team's simple memory-mapped peripheral bus (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata).
- Accepts single read/write commands on a valid/ready command port and runs exactly one bus transaction per command.
- Returns read data and an error flag on a valid/ready response port.
- Sits between the loader control logic (e.g. host-command decoder) and the peripheral address decoder feeding gpio and similar responders.

Parameters:
- ADDR_W, 32, width of cmd_addr and mem_addr.
- TIMEOUT_CYCLES, 256, maximum cycles mem_valid is held without mem_ready before abort. Used only with MEM_TIMEOUT_EN. Legal range is 2..65535.

Ports:
- mem_clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  32  write data.
- cmd_wstrb  input  4  byte strobes for writes; ignored for reads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  output  32  read data; 0 for writes and for aborted transactions.
- rsp_err  output  1  1 = transaction aborted by timeout.
- mem_valid  output  1  bus request.
- mem_addr  output  ADDR_W  bus address.
- mem_wdata  output  32  bus write data.
- mem_wstrb  output  4  bus strobes; forced to 4'h0 for reads.
- mem_ready  input  1  responder completion; sampled only while mem_valid = 1.
- mem_rdata  input  32  responder read data; sampled in the cycle where mem_valid & mem_ready.
- busy  output  1  high whenever state != IDLE.
- err_count  output  8  saturating count of aborted transactions.

Behaviour:
- Reset values: state IDLE, cmd_ready 1, all other outputs 0, err_count 0, timeout counter 0.
- A mid-transaction reset drops mem_valid at the next edge and discards any pending response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch addr, wdata and write flag. Latch wstrb = cmd_write ? cmd_wstrb : 4'h0.
  - Next state is ACCESS.
- ACCESS:
  - mem_valid = 1. mem_addr, mem_wdata and mem_wstrb are held constant from the latched command for the whole state.
  - cmd_ready = 0.
  - If mem_ready: capture rsp_rdata = write ? 0 : mem_rdata, set rsp_err = 0, go to RESP.
  - mem_valid is deasserted in the cycle after mem_ready was seen.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - A new command is never accepted in the same cycle as the response handshake.
- Latency:
  - Command accepted at edge N. mem_valid is high in cycle N+1.
  - If mem_ready arrives in the same cycle, rsp_valid is high in cycle N+2.
  - Minimum 3 cycles per transaction with rsp_ready tied high.
- mem_ready while mem_valid = 0 is ignored. mem_valid never asserts in IDLE or RESP.
- mem_addr, mem_wdata and mem_wstrb keep their last value outside ACCESS.
- err_count increments once per aborted transaction and saturates at 8'hFF.
- No outstanding-transaction pipelining: exactly one transaction is in flight.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ready is still 0, the transaction aborts: rsp_err = 1, rsp_rdata = 0, err_count increments, next state RESP, mem_valid drops the next cycle.
  - If mem_ready arrives in the same cycle as the terminal count, the transaction completes normally with rsp_err = 0.
- Undefined:
  - No counter; ACCESS waits indefinitely for mem_ready.
  - rsp_err is constantly 0 and err_count is constantly 0.

Test Plan:
- Zero-wait write, with mem_ready tied to mem_valid: cmd write addr 0x0, wdata 0x000000A5, wstrb 4'hF -> in cycle N+1, mem_valid = 1, mem_addr = 0, mem_wdata = 0xA5, mem_wstrb = 4'hF; in cycle N+2, rsp_valid = 1, rsp_rdata = 0, rsp_err = 0.
- Read: cmd read addr 0x4, responder returns mem_rdata = 0x0000003C with 3 wait cycles -> mem_wstrb = 0; mem_valid high for 4 cycles with addr stable; rsp_rdata = 0x3C.
- Response backpressure: rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable; cmd_ready = 0 throughout; 2nd command accepted only after the rsp handshake.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4), mem_ready never asserted -> mem_valid high exactly 4 cycles, then rsp_err = 1, rsp_rdata = 0, err_count = 1. A 2nd hung access gives err_count = 2.
- Boundary (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4): mem_ready arrives on the 4th ACCESS cycle -> rsp_err = 0, data captured, err_count unchanged.
- Reset mid-ACCESS: assert rst for 1 cycle while mem_valid = 1 -> mem_valid = 0, busy = 0, cmd_ready = 1 at the next edge; no rsp_valid pulse is produced.
